// File: rtl/abacus_pkg.sv
// Shared constants, op codes and sequencer state encoding
// for the abacus arithmetic datapath and its controller.
package abacus_pkg;

  localparam int OPND_W = 3;
  localparam int RES_W  = 6;
  localparam int SEL_W  = 2;

  typedef enum logic [SEL_W-1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/abacus_op_sequencer_if.sv
// Request/response handshake bundle between a client
// and the abacus op sequencer.
interface abacus_op_sequencer_if;
  import abacus_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [OPND_W-1:0] req_in1;
  logic [OPND_W-1:0] req_in2;
  logic [SEL_W-1:0]  req_sel;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [RES_W-1:0]  rsp_result;
  logic              rsp_overflow;
  logic              rsp_divzero;

  modport master (
    output req_valid, req_in1, req_in2, req_sel,
    output rsp_ready,
    input  req_ready,
    input  rsp_valid, rsp_result, rsp_overflow,
    input  rsp_divzero
  );

  modport slave (
    input  req_valid, req_in1, req_in2, req_sel,
    input  rsp_ready,
    output req_ready,
    output rsp_valid, rsp_result, rsp_overflow,
    output rsp_divzero
  );

endinterface

// File: rtl/abacus_op_sequencer.sv
// Issues one op at a time to the abacus datapath, waits
// its latency, returns the result; traps divide-by-zero.
module abacus_op_sequencer
  import abacus_pkg::*;
#(
  parameter int DP_LATENCY = 1,
  parameter int OVF_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  abacus_op_sequencer_if.slave bus,
  output logic [OPND_W-1:0]    dp_in1,
  output logic [OPND_W-1:0]    dp_in2,
  output logic [SEL_W-1:0]     dp_sel,
  input  logic [RES_W-1:0]     dp_result,
  input  logic                 dp_overflow,
  output logic                 busy,
  input  logic                 ovf_clr,
  output logic [OVF_CNT_W-1:0] ovf_count
);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [OPND_W-1:0] in1_d, in2_d;
  logic [SEL_W-1:0]  sel_d;
  logic [RES_W-1:0]  res_q, res_d;
  logic              rovf_q, rovf_d;
  logic              dz_q, dz_d;
  logic              cap_ovf;

  assign bus.req_ready    = (state_q == ST_IDLE);
  assign bus.rsp_valid    = (state_q == ST_DONE);
  assign bus.rsp_result   = res_q;
  assign bus.rsp_overflow = rovf_q;
  assign bus.rsp_divzero  = dz_q;
  assign busy             = (state_q != ST_IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    in1_d   = dp_in1;
    in2_d   = dp_in2;
    sel_d   = dp_sel;
    res_d   = res_q;
    rovf_d  = rovf_q;
    dz_d    = dz_q;
    cap_ovf = 1'b0;
    unique case (1'b1)
      (state_q == ST_IDLE): begin
        if (bus.req_valid) begin
          // Divide-by-zero never reaches the datapath.
          if (bus.req_sel == OP_DIV &&
              bus.req_in2 == '0) begin
            res_d   = '0;
            rovf_d  = 1'b0;
            dz_d    = 1'b1;
            state_d = ST_DONE;
          end else begin
            in1_d   = bus.req_in1;
            in2_d   = bus.req_in2;
            sel_d   = bus.req_sel;
            cnt_d   = 4'(DP_LATENCY);
            state_d = ST_WAIT;
          end
        end
      end
      (state_q == ST_WAIT): begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          res_d   = dp_result;
          rovf_d  = dp_overflow;
          dz_d    = 1'b0;
          cap_ovf = dp_overflow;
          state_d = ST_DONE;
        end
      end
      (state_q == ST_DONE): begin
        if (bus.rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      dp_in1    <= '0;
      dp_in2    <= '0;
      dp_sel    <= '0;
      res_q     <= '0;
      rovf_q    <= 1'b0;
      dz_q      <= 1'b0;
      ovf_count <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dp_in1  <= in1_d;
      dp_in2  <= in2_d;
      dp_sel  <= sel_d;
      res_q   <= res_d;
      rovf_q  <= rovf_d;
      dz_q    <= dz_d;
      // Clear beats a same-edge increment.
      if (ovf_clr)
        ovf_count <= '0;
      else if (cap_ovf && ovf_count != '1)
        ovf_count <= ovf_count + OVF_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_abacus_op_sequencer.sv
// Directed bench: three sequencers (latency 1/0/15)
// each paired with a behavioural abacus datapath.
module tb_abacus_op_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  abacus_op_sequencer_if bus_a();
  abacus_op_sequencer_if bus_b();
  abacus_op_sequencer_if bus_c();

  logic [2:0] a_dp_in1, a_dp_in2, b_dp_in1, b_dp_in2;
  logic [2:0] c_dp_in1, c_dp_in2;
  logic [1:0] a_dp_sel, b_dp_sel, c_dp_sel;
  logic [5:0] a_dp_result, b_dp_result, c_dp_result;
  logic       a_dp_overflow, b_dp_overflow, c_dp_overflow;
  logic       a_busy, b_busy, c_busy;
  logic       a_clr, b_clr, c_clr;
  logic [1:0] a_cnt;
  logic [7:0] b_cnt, c_cnt;

  // Datapath stand-in: overflow flags a subtract borrow.
  function automatic logic [6:0] dp_model(
    logic [2:0] x, logic [2:0] y, logic [1:0] s);
    logic [5:0] r;
    logic       o;
    r = '0;
    o = 1'b0;
    case (s)
      2'd0: r = 6'(x) + 6'(y);
      2'd1: begin
        r = 6'(x) - 6'(y);
        o = (x < y);
      end
      2'd2: r = 6'(x) * 6'(y);
      default: r = (y == 0) ? 6'd0 : 6'(x) / 6'(y);
    endcase
    return {o, r};
  endfunction

  logic [6:0] pipe_a [16];
  logic [6:0] pipe_c [16];

  always_ff @(posedge clk) begin
    pipe_a[0] <= dp_model(a_dp_in1, a_dp_in2, a_dp_sel);
    pipe_c[0] <= dp_model(c_dp_in1, c_dp_in2, c_dp_sel);
    for (int i = 1; i < 16; i++) begin
      pipe_a[i] <= pipe_a[i-1];
      pipe_c[i] <= pipe_c[i-1];
    end
  end

  assign {a_dp_overflow, a_dp_result} = pipe_a[0];
  assign {b_dp_overflow, b_dp_result} =
    dp_model(b_dp_in1, b_dp_in2, b_dp_sel);
  assign {c_dp_overflow, c_dp_result} = pipe_c[14];

  abacus_op_sequencer #(.DP_LATENCY(1), .OVF_CNT_W(2)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a),
    .dp_in1(a_dp_in1), .dp_in2(a_dp_in2),
    .dp_sel(a_dp_sel), .dp_result(a_dp_result),
    .dp_overflow(a_dp_overflow), .busy(a_busy),
    .ovf_clr(a_clr), .ovf_count(a_cnt)
  );

  abacus_op_sequencer #(.DP_LATENCY(0), .OVF_CNT_W(8)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b),
    .dp_in1(b_dp_in1), .dp_in2(b_dp_in2),
    .dp_sel(b_dp_sel), .dp_result(b_dp_result),
    .dp_overflow(b_dp_overflow), .busy(b_busy),
    .ovf_clr(b_clr), .ovf_count(b_cnt)
  );

  abacus_op_sequencer #(.DP_LATENCY(15), .OVF_CNT_W(8)) dut_c (
    .clk(clk), .rst(rst), .bus(bus_c),
    .dp_in1(c_dp_in1), .dp_in2(c_dp_in2),
    .dp_sel(c_dp_sel), .dp_result(c_dp_result),
    .dp_overflow(c_dp_overflow), .busy(c_busy),
    .ovf_clr(c_clr), .ovf_count(c_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(logic [2:0] x, logic [2:0] y,
                         logic [1:0] s, logic v);
    bus_a.req_in1 = x;
    bus_a.req_in2 = y;
    bus_a.req_sel = s;
    bus_a.req_valid = v;
  endtask

  task automatic drive_bc(int which, logic [2:0] x,
                          logic [2:0] y, logic [1:0] s,
                          logic v);
    if (which == 0) begin
      bus_b.req_in1 = x;
      bus_b.req_in2 = y;
      bus_b.req_sel = s;
      bus_b.req_valid = v;
    end else begin
      bus_c.req_in1 = x;
      bus_c.req_in2 = y;
      bus_c.req_sel = s;
      bus_c.req_valid = v;
    end
  endtask

  // Issue one op on A and accept its response; got=0 on timeout.
  task automatic run_op_a(logic [2:0] x, logic [2:0] y,
                          logic [1:0] s, output logic got);
    drive_a(x, y, s, 1'b1);
    bus_a.rsp_ready = 1'b0;
    step();
    bus_a.req_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (bus_a.rsp_valid) got = 1'b1;
      else step();
    end
    bus_a.rsp_ready = 1'b1;
    step();
    bus_a.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_a(3'd0, 3'd0, 2'd0, 1'b0);
    drive_bc(0, 3'd0, 3'd0, 2'd0, 1'b0);
    drive_bc(1, 3'd0, 3'd0, 2'd0, 1'b0);
    bus_a.rsp_ready = 1'b0;
    bus_b.rsp_ready = 1'b0;
    bus_c.rsp_ready = 1'b0;
    a_clr = 1'b0;
    b_clr = 1'b0;
    c_clr = 1'b0;
    step();
    step();
    total++;
    if ({bus_a.req_ready, bus_a.rsp_valid, a_busy}
        !== 3'b100) begin
      bad++;
      $display("FAIL rst_hs got=%b want=100",
        {bus_a.req_ready, bus_a.rsp_valid, a_busy});
    end
    total++;
    if ({bus_a.rsp_result, bus_a.rsp_overflow,
         bus_a.rsp_divzero} !== 8'd0) begin
      bad++;
      $display("FAIL rst_rsp got=%h want=0", {bus_a.rsp_result,
        bus_a.rsp_overflow, bus_a.rsp_divzero});
    end
    total++;
    if ({a_dp_in1, a_dp_in2, a_dp_sel, a_cnt} !== 10'd0) begin
      bad++;
      $display("FAIL rst_dp got=%h want=0",
        {a_dp_in1, a_dp_in2, a_dp_sel, a_cnt});
    end
    total++;
    if ({b_busy, c_busy, b_cnt, c_cnt} !== 18'd0) begin
      bad++;
      $display("FAIL rst_bc got=%h want=0",
        {b_busy, c_busy, b_cnt, c_cnt});
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_add();
    drive_a(3'd3, 3'd4, 2'd0, 1'b1);
    bus_a.rsp_ready = 1'b1;
    total++;
    if (bus_a.req_ready !== 1'b1) begin
      bad++;
      $display("FAIL add_ready got=%b want=1", bus_a.req_ready);
    end
    step();
    bus_a.req_valid = 1'b0;
    total++;
    if ({a_dp_in1, a_dp_in2, a_dp_sel} !== {3'd3, 3'd4, 2'd0})
    begin
      bad++;
      $display("FAIL add_dp got=%0d,%0d,%0d want=3,4,0",
        a_dp_in1, a_dp_in2, a_dp_sel);
    end
    total++;
    if ({bus_a.req_ready, bus_a.rsp_valid, a_busy} !== 3'b001)
    begin
      bad++;
      $display("FAIL add_t1 got=%b want=001",
        {bus_a.req_ready, bus_a.rsp_valid, a_busy});
    end
    step();
    total++;
    if (bus_a.rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL add_t2_valid got=%b want=0", bus_a.rsp_valid);
    end
    step();
    total++;
    if ({bus_a.rsp_valid, bus_a.rsp_result, bus_a.rsp_overflow,
         bus_a.rsp_divzero} !== {1'b1, 6'd7, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL add_rsp got=%b/%0d/%b/%b want=1/7/0/0",
        bus_a.rsp_valid, bus_a.rsp_result,
        bus_a.rsp_overflow, bus_a.rsp_divzero);
    end
    step();
    total++;
    if ({bus_a.req_ready, bus_a.rsp_valid} !== 2'b10) begin
      bad++;
      $display("FAIL add_t4 got=%b want=10",
        {bus_a.req_ready, bus_a.rsp_valid});
    end
  endtask

  task automatic test_divzero();
    drive_a(3'd5, 3'd0, 2'd3, 1'b1);
    bus_a.rsp_ready = 1'b1;
    step();
    bus_a.req_valid = 1'b0;
    total++;
    if ({bus_a.rsp_valid, bus_a.rsp_divzero, bus_a.rsp_result,
         bus_a.rsp_overflow} !== {1'b1, 1'b1, 6'd0, 1'b0}) begin
      bad++;
      $display("FAIL dz_rsp got=%b/%b/%0d/%b want=1/1/0/0",
        bus_a.rsp_valid, bus_a.rsp_divzero,
        bus_a.rsp_result, bus_a.rsp_overflow);
    end
    total++;
    if ({a_dp_in1, a_dp_in2, a_dp_sel, a_cnt} !==
        {3'd3, 3'd4, 2'd0, 2'd0}) begin
      bad++;
      $display("FAIL dz_dp got=%0d,%0d,%0d cnt=%0d want=3,4,0 cnt=0",
        a_dp_in1, a_dp_in2, a_dp_sel, a_cnt);
    end
    step();
    total++;
    if ({bus_a.req_ready, bus_a.rsp_valid} !== 2'b10) begin
      bad++;
      $display("FAIL dz_back got=%b want=10",
        {bus_a.req_ready, bus_a.rsp_valid});
    end
  endtask

  task automatic test_backpressure();
    logic got;
    drive_a(3'd7, 3'd7, 2'd2, 1'b1);
    bus_a.rsp_ready = 1'b0;
    step();
    bus_a.req_valid = 1'b0;
    step();
    step();
    drive_a(3'd1, 3'd2, 2'd0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      total++;
      if ({bus_a.rsp_valid, bus_a.req_ready, bus_a.rsp_result,
           a_dp_in1} !== {1'b1, 1'b0, 6'd49, 3'd7}) begin
        bad++;
        $display("FAIL bp_hold%0d got=%b/%b/%0d/%0d want=1/0/49/7",
          k, bus_a.rsp_valid, bus_a.req_ready,
          bus_a.rsp_result, a_dp_in1);
      end
      step();
    end
    bus_a.rsp_ready = 1'b1;
    step();
    bus_a.rsp_ready = 1'b0;
    total++;
    if ({bus_a.req_ready, bus_a.rsp_valid} !== 2'b10) begin
      bad++;
      $display("FAIL bp_idle got=%b want=10",
        {bus_a.req_ready, bus_a.rsp_valid});
    end
    step();
    bus_a.req_valid = 1'b0;
    total++;
    if ({a_dp_in1, a_dp_in2, a_busy} !== {3'd1, 3'd2, 1'b1})
    begin
      bad++;
      $display("FAIL bp_accept got=%0d,%0d,%b want=1,2,1",
        a_dp_in1, a_dp_in2, a_busy);
    end
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (bus_a.rsp_valid) got = 1'b1;
      else step();
    end
    total++;
    if (!got || bus_a.rsp_result !== 6'd3) begin
      bad++;
      $display("FAIL bp_second got=%b/%0d want=1/3",
        got, bus_a.rsp_result);
    end
    bus_a.rsp_ready = 1'b1;
    step();
    bus_a.rsp_ready = 1'b0;
  endtask

  task automatic test_ovf_count();
    logic got;
    logic [2:0] xs [4];
    logic [2:0] ys [4];
    logic [1:0] want [4];
    xs = '{3'd1, 3'd0, 3'd2, 3'd4};
    ys = '{3'd3, 3'd7, 3'd5, 3'd6};
    want = '{2'd1, 2'd2, 2'd3, 2'd3};
    total++;
    if (a_cnt !== 2'd0) begin
      bad++;
      $display("FAIL ovf_start got=%0d want=0", a_cnt);
    end
    for (int k = 0; k < 4; k++) begin
      run_op_a(xs[k], ys[k], 2'd1, got);
      total++;
      if (!got || a_cnt !== want[k]) begin
        bad++;
        $display("FAIL ovf_cnt%0d got=%b/%0d want=1/%0d",
          k, got, a_cnt, want[k]);
      end
    end
    drive_a(3'd0, 3'd1, 2'd1, 1'b1);
    step();
    bus_a.req_valid = 1'b0;
    step();
    a_clr = 1'b1;
    step();
    a_clr = 1'b0;
    total++;
    if ({a_cnt, bus_a.rsp_valid, bus_a.rsp_overflow,
         bus_a.rsp_result} !== {2'd0, 1'b1, 1'b1, 6'd63}) begin
      bad++;
      $display("FAIL ovf_clr got=%0d/%b/%b/%0d want=0/1/1/63",
        a_cnt, bus_a.rsp_valid, bus_a.rsp_overflow,
        bus_a.rsp_result);
    end
    bus_a.rsp_ready = 1'b1;
    step();
    bus_a.rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic got;
    int   seen;
    drive_a(3'd2, 3'd2, 2'd0, 1'b1);
    bus_a.rsp_ready = 1'b1;
    step();
    bus_a.req_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++;
    if ({bus_a.req_ready, bus_a.rsp_valid, a_busy,
         bus_a.rsp_result, bus_a.rsp_overflow,
         bus_a.rsp_divzero} !== {3'b100, 8'd0}) begin
      bad++;
      $display("FAIL rmid_out got=%b want=10000000000",
        {bus_a.req_ready, bus_a.rsp_valid, a_busy,
         bus_a.rsp_result, bus_a.rsp_overflow,
         bus_a.rsp_divzero});
    end
    total++;
    if ({a_dp_in1, a_dp_in2, a_dp_sel, a_cnt} !== 10'd0) begin
      bad++;
      $display("FAIL rmid_dp got=%h want=0",
        {a_dp_in1, a_dp_in2, a_dp_sel, a_cnt});
    end
    drive_a(3'd2, 3'd3, 2'd0, 1'b1);
    step();
    bus_a.req_valid = 1'b0;
    total++;
    if ({a_busy, a_dp_in1, a_dp_in2} !== {1'b1, 3'd2, 3'd3})
    begin
      bad++;
      $display("FAIL rmid_new got=%b/%0d/%0d want=1/2/3",
        a_busy, a_dp_in1, a_dp_in2);
    end
    got = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus_a.rsp_valid) begin
        seen++;
        if (bus_a.rsp_result === 6'd5) got = 1'b1;
      end
      step();
    end
    total++;
    if (!got || seen != 1) begin
      bad++;
      $display("FAIL rmid_rsp got=%b seen=%0d want=1 seen=1",
        got, seen);
    end
    bus_a.rsp_ready = 1'b0;
  endtask

  task automatic test_throughput(int which);
    logic [2:0] xs [10];
    logic [2:0] ys [10];
    logic [1:0] ss [10];
    int         t [10];
    int         k, r, per;
    logic       acc, rv;
    logic [6:0] got;
    per = (which == 0) ? 3 : 18;
    for (int i = 0; i < 10; i++) begin
      xs[i] = 3'($urandom_range(0, 7));
      ys[i] = 3'($urandom_range(0, 7));
      ss[i] = 2'($urandom_range(0, 3));
      if (ss[i] == 2'd3 && ys[i] == 3'd0) ys[i] = 3'd1;
      t[i] = 0;
    end
    k = 0;
    r = 0;
    drive_bc(which, xs[0], ys[0], ss[0], 1'b1);
    bus_b.rsp_ready = (which == 0);
    bus_c.rsp_ready = (which != 0);
    for (int cyc = 0; cyc < 400 && r < 10; cyc++) begin
      if (which == 0) begin
        acc = bus_b.req_valid & bus_b.req_ready;
        rv  = bus_b.rsp_valid;
        got = {bus_b.rsp_overflow, bus_b.rsp_result};
      end else begin
        acc = bus_c.req_valid & bus_c.req_ready;
        rv  = bus_c.rsp_valid;
        got = {bus_c.rsp_overflow, bus_c.rsp_result};
      end
      if (acc) t[k] = cyc;
      if (rv) begin
        total++;
        if (got !== dp_model(xs[r], ys[r], ss[r])) begin
          bad++;
          $display("FAIL thr%0d_res%0d got=%h want=%h", which, r,
            got, dp_model(xs[r], ys[r], ss[r]));
        end
        r++;
      end
      step();
      if (acc) begin
        k++;
        if (k < 10) drive_bc(which, xs[k], ys[k], ss[k], 1'b1);
        else drive_bc(which, 3'd0, 3'd0, 2'd0, 1'b0);
      end
    end
    bus_b.rsp_ready = 1'b0;
    bus_c.rsp_ready = 1'b0;
    total++;
    if (r != 10) begin
      bad++;
      $display("FAIL thr%0d_count got=%0d want=10", which, r);
    end
    for (int i = 1; i < 10; i++) begin
      total++;
      if (t[i] - t[i-1] != per) begin
        bad++;
        $display("FAIL thr%0d_period%0d got=%0d want=%0d",
          which, i, t[i] - t[i-1], per);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_divzero();
    test_backpressure();
    test_ovf_count();
    test_reset_mid();
    test_throughput(0);
    test_throughput(1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
